// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: stage-register state encoding and bubble constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam logic [63:0] PIPE_NOP = 64'h0;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+data storage entry with load/clear/hold; clear rewrites the data with the bubble value.
module pipe_entry_reg #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = BUBBLE_VAL;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= BUBBLE_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register: main entry plus one skid entry so in_ready never depends on out_ready.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W            = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL        = '0,
  parameter bit                FLUSH_OVER_FREEZE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  pipe_state_t       state_q, state_d;
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data, main_load_data;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              in_fire, out_fire, flush_eff;

  assign in_ready  = ~freeze & (state_q != FULL);
  assign out_valid = ~freeze & main_valid;
  assign out_data  = main_data;
  assign occupancy = occ_count(main_valid, skid_valid);

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // With freeze dominant, a flush raised during freeze is dropped, not remembered.
  assign flush_eff = flush & (FLUSH_OVER_FREEZE ? 1'b1 : ~freeze);

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush_eff) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_load_data = main_from_skid ? skid_data : in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  pipe_entry_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_load_data),
    .valid     (main_valid),
    .data      (main_data)
  );

  pipe_entry_reg #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_data),
    .valid     (skid_valid),
    .data      (skid_data)
  );

  a_skid_implies_main: assert property (@(posedge clk) disable iff (rst)
    !(skid_valid && !main_valid));

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed table-driven bench for pipe_stage_skid_reg, with both flush/freeze priority variants.
module tb_pipe_stage_skid_reg;

  localparam int          W   = 16;
  localparam logic [W-1:0] BUB = 16'hBEEF;
  localparam logic [W-1:0] DA  = 16'h00A1;
  localparam logic [W-1:0] DB  = 16'h00B2;
  localparam logic [W-1:0] DC  = 16'h00C3;

  logic         clk = 1'b0;
  logic         rst, flush, freeze, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready0, out_valid0, in_ready1, out_valid1;
  logic [W-1:0] out_data0, out_data1;
  logic [1:0]   occ0, occ1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_reg #(.DATA_W(W), .BUBBLE_VAL(BUB), .FLUSH_OVER_FREEZE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .occupancy(occ0));

  pipe_stage_skid_reg #(.DATA_W(W), .BUBBLE_VAL(BUB), .FLUSH_OVER_FREEZE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occ1));

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         fz;
    logic         eov;
    logic [W-1:0] eod;
    logic         erdy;
    logic [1:0]   eocc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic [W-1:0] id, input logic ordy,
                     input logic fl, input logic fz, input logic eov,
                     input logic [W-1:0] eod, input logic erdy, input logic [1:0] eocc);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl; v.fz = fz;
    v.eov = eov; v.eod = eod; v.erdy = erdy; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_dut0(input string tag, input logic eov, input logic [W-1:0] eod,
                          input logic erdy, input logic [1:0] eocc);
    chk({tag, " d0 out_valid"}, 32'(out_valid0), 32'(eov));
    chk({tag, " d0 out_data"},  32'(out_data0),  32'(eod));
    chk({tag, " d0 in_ready"},  32'(in_ready0),  32'(erdy));
    chk({tag, " d0 occ"},       32'(occ0),       32'(eocc));
  endtask

  task automatic chk_dut1(input string tag, input logic eov, input logic [W-1:0] eod,
                          input logic erdy, input logic [1:0] eocc);
    chk({tag, " d1 out_valid"}, 32'(out_valid1), 32'(eov));
    chk({tag, " d1 out_data"},  32'(out_data1),  32'(eod));
    chk({tag, " d1 in_ready"},  32'(in_ready1),  32'(erdy));
    chk({tag, " d1 occ"},       32'(occ1),       32'(eocc));
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl, input logic fz);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl; freeze = fz;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Stream 1..8 with out_ready=1: each value one cycle later, occupancy 1.
    add(1, 16'd1, 1, 0, 0, 0, BUB, 1, 0);
    for (int i = 2; i <= 8; i++) add(1, 16'(i), 1, 0, 0, 1, 16'(i - 1), 1, 1);
    add(0, '0, 1, 0, 0, 1, 16'd8, 1, 1);
    add(0, '0, 1, 0, 0, 0, BUB, 1, 0);
    // Backpressure: A,B accepted, C refused while FULL, then drain in order.
    add(1, DA, 0, 0, 0, 0, BUB, 1, 0);
    add(1, DB, 0, 0, 0, 1, DA, 1, 1);
    add(1, DC, 0, 0, 0, 1, DA, 0, 2);
    add(0, '0, 1, 0, 0, 1, DA, 0, 2);
    add(0, '0, 1, 0, 0, 1, DB, 1, 1);
    add(0, '0, 0, 0, 0, 0, BUB, 1, 0);
    // Flush from FULL with C offered.
    add(1, DA, 0, 0, 0, 0, BUB, 1, 0);
    add(1, DB, 0, 0, 0, 1, DA, 1, 1);
    add(1, DC, 0, 1, 0, 1, DA, 0, 2);
    add(0, '0, 0, 0, 0, 0, BUB, 1, 0);
    add(0, '0, 0, 0, 0, 0, BUB, 1, 0);
    // Flush from ONE with an accepted C: C is discarded.
    add(1, DA, 0, 0, 0, 0, BUB, 1, 0);
    add(1, DC, 0, 1, 0, 1, DA, 1, 1);
    add(0, '0, 1, 0, 0, 0, BUB, 1, 0);
    // Freeze while FULL for 3 cycles with out_ready=1, then release.
    add(1, DA, 0, 0, 0, 0, BUB, 1, 0);
    add(1, DB, 0, 0, 0, 1, DA, 1, 1);
    for (int i = 0; i < 3; i++) add(1, DC, 1, 0, 1, 0, DA, 0, 2);
    add(0, '0, 1, 0, 0, 1, DA, 0, 2);
    add(0, '0, 1, 0, 0, 1, DB, 1, 1);
    add(0, '0, 1, 0, 0, 0, BUB, 1, 0);

    #12;
    chk_dut0("reset", 1'b0, BUB, 1'b1, 2'd0);
    chk_dut1("reset", 1'b0, BUB, 1'b1, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, vecs[i].fz);
      #1;
      chk_dut0($sformatf("row%0d", i), vecs[i].eov, vecs[i].eod, vecs[i].erdy, vecs[i].eocc);
      chk_dut1($sformatf("row%0d", i), vecs[i].eov, vecs[i].eod, vecs[i].erdy, vecs[i].eocc);
    end

    // Priority: freeze and flush together while FULL.
    @(negedge clk); drive(1'b1, DA, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, DB, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    #1;
    chk_dut0("prio_during", 1'b0, DA, 1'b0, 2'd2);
    chk_dut1("prio_during", 1'b0, DA, 1'b0, 2'd2);
    @(negedge clk); drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_dut0("prio_after", 1'b1, DA, 1'b0, 2'd2);
    chk_dut1("prio_after", 1'b0, BUB, 1'b1, 2'd0);
    @(negedge clk); drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    #1;
    chk_dut0("prio_drain", 1'b1, DA, 1'b0, 2'd2);
    @(negedge clk);
    #1;
    chk_dut0("prio_drain2", 1'b1, DB, 1'b1, 2'd1);

    // Asynchronous reset mid-stream, away from any clock edge.
    @(negedge clk); drive(1'b1, DA, 1'b0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, DB, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    chk_dut0("pre_rst", 1'b1, DA, 1'b0, 2'd2);
    rst = 1'b1;
    #1;
    chk_dut0("mid_rst", 1'b0, BUB, 1'b1, 2'd0);
    chk_dut1("mid_rst", 1'b0, BUB, 1'b1, 2'd0);
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk_dut0("post_rst", 1'b0, BUB, 1'b1, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
